// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Eight-line edge-triggered interrupt collector with mask,
//               fixed priority (bit 0 highest) and capture/ack handshake.
// Revision    : 1.0  initial release
// ============================================================================
module interrupt_controller #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               irq_en,
    input  logic [NUM_IRQ-1:0] z_bus,
    input  logic               ctrl_mask_flags_wrt,
    input  logic               ctrl_int_vector_wrt,
    input  logic               ctrl_int_ack,
    input  logic               ctrl_clear_all_ints,
    output logic               int_pending,
    output logic [7:0]         int_vector,
    output logic [NUM_IRQ-1:0] int_mask,
    output logic [NUM_IRQ-1:0] int_status
);

    localparam int c_IDX_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_CAPTURED = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
    logic [NUM_IRQ-1:0]                  r_edge_q;
    logic [NUM_IRQ-1:0]                  r_pending;
    logic [NUM_IRQ-1:0]                  r_mask;
    logic [c_IDX_W-1:0]                  r_cap_idx;
    logic [7:0]                          r_int_vector;
    state_t                              r_state;
    state_t                              w_state_nxt;

    logic [NUM_IRQ-1:0]                  w_edge;
    logic [NUM_IRQ-1:0]                  w_active;
    logic                                w_any;
    logic [c_IDX_W-1:0]                  w_idx;
    logic                                w_capture;
    logic                                w_retire;
    logic [NUM_IRQ-1:0]                  w_clr_bits;
    logic [NUM_IRQ-1:0]                  w_pending_nxt;

    // Synchroniser chain followed by the edge-history flop
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_sync   <= '0;
            r_edge_q <= '0;
        end else begin
            r_sync[0] <= irq;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_edge_q <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge   = r_sync[SYNC_STAGES-1] & ~r_edge_q;
    assign w_active = r_pending & r_mask;
    assign w_any    = |w_active;

    // Lowest set bit wins: scan from the top so bit 0 is written last
    always_comb begin
        w_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_idx = c_IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!ctrl_clear_all_ints && !ctrl_int_vector_wrt && w_any) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_CAPTURED;
                end
            end
            ST_CAPTURED: begin
                if (ctrl_clear_all_ints) begin
                    w_state_nxt = ST_IDLE;
                end else if (ctrl_int_ack) begin
                    w_retire    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // New edges are OR-ed in last so they survive a same-cycle clear
    always_comb begin
        w_clr_bits = '0;
        if (ctrl_clear_all_ints) begin
            w_clr_bits = '1;
        end else if (w_retire) begin
            w_clr_bits = NUM_IRQ'(1) << r_cap_idx;
        end
        w_pending_nxt = (r_pending & ~w_clr_bits) | w_edge;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_mask       <= '0;
            r_cap_idx    <= '0;
            r_int_vector <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (!ctrl_mask_flags_wrt) begin
                r_mask <= z_bus;
            end
            if (w_capture) begin
                r_cap_idx    <= w_idx;
                r_int_vector <= {w_idx, 5'b00000};
            end
        end
    end

    assign int_pending = (r_state == ST_IDLE) & irq_en & w_any;
    assign int_vector  = r_int_vector;
    assign int_mask    = r_mask;
    assign int_status  = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// Bench for interrupt_controller: directed scenarios then random traffic,
// each cycle's expected outputs queued by a reference model and checked by a monitor.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [7:0] irq = 8'h00;
    logic       irq_en = 1'b0;
    logic [7:0] z_bus = 8'h00;
    logic       ctrl_mask_flags_wrt = 1'b1;
    logic       ctrl_int_vector_wrt = 1'b1;
    logic       ctrl_int_ack = 1'b0;
    logic       ctrl_clear_all_ints = 1'b0;
    logic       int_pending;
    logic [7:0] int_vector;
    logic [7:0] int_mask;
    logic [7:0] int_status;

    interrupt_controller #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk                 (clk),
        .arst_n              (arst_n),
        .irq                 (irq),
        .irq_en              (irq_en),
        .z_bus               (z_bus),
        .ctrl_mask_flags_wrt (ctrl_mask_flags_wrt),
        .ctrl_int_vector_wrt (ctrl_int_vector_wrt),
        .ctrl_int_ack        (ctrl_int_ack),
        .ctrl_clear_all_ints (ctrl_clear_all_ints),
        .int_pending         (int_pending),
        .int_vector          (int_vector),
        .int_mask            (int_mask),
        .int_status          (int_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       p;
        logic [7:0] v;
        logic [7:0] m;
        logic [7:0] s;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: irq samples seen at recent edges, pending set, mask,
    // and the captured line (if any).
    bit [7:0] h[3];
    bit [7:0] m_pend, m_mask, m_vec;
    bit       m_capt;
    int       m_cap;

    task automatic step_model();
        bit [7:0] rise;
        bit [7:0] act;
        int       idx;
        exp_t     e;
        if (!arst_n) begin
            h[0] = 0; h[1] = 0; h[2] = 0;
            m_pend = 0; m_mask = 0; m_vec = 0; m_capt = 0; m_cap = 0;
        end else begin
            // a line counts as risen once it was seen high two edges ago after being low
            rise = h[1] & ~h[2];
            h[2] = h[1]; h[1] = h[0]; h[0] = irq;
            act = m_pend & m_mask;
            idx = -1;
            for (int i = 7; i >= 0; i--) if (act[i]) idx = i;
            if (ctrl_clear_all_ints) begin
                m_pend = 0;
                m_capt = 0;
            end else if (m_capt) begin
                if (ctrl_int_ack) begin
                    m_pend[m_cap] = 1'b0;
                    m_capt = 0;
                end
            end else if (!ctrl_int_vector_wrt && idx >= 0) begin
                m_cap  = idx;
                m_vec  = 8'(idx * 32);
                m_capt = 1;
            end
            m_pend = m_pend | rise;
            if (!ctrl_mask_flags_wrt) m_mask = z_bus;
        end
        e.p = !m_capt && irq_en && ((m_pend & m_mask) != 0);
        e.v = m_vec;
        e.m = m_mask;
        e.s = m_pend;
        q.push_back(e);
    endtask

    task automatic tick(input bit rn, input bit [7:0] ir, input bit en, input bit [7:0] z,
                        input bit mw, input bit vw, input bit ak, input bit cl);
        @(negedge clk);
        arst_n = rn; irq = ir; irq_en = en; z_bus = z;
        ctrl_mask_flags_wrt = mw; ctrl_int_vector_wrt = vw;
        ctrl_int_ack = ak; ctrl_clear_all_ints = cl;
        step_model();
    endtask

    task automatic idle(input bit [7:0] ir, input int n);
        for (int k = 0; k < n; k++) tick(1, ir, 1, 8'h00, 1, 1, 0, 0);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("int_pending", {7'b0, int_pending}, {7'b0, e.p});
                chk("int_vector", int_vector, e.v);
                chk("int_mask", int_mask, e.m);
                chk("int_status", int_status, e.s);
            end
        end
    end

    initial begin
        bit [7:0] ir;
        // Reset, unmask all, single line 3
        tick(0, 8'h00, 1, 8'h00, 1, 1, 0, 0);
        tick(0, 8'h00, 1, 8'h00, 1, 1, 0, 0);
        tick(1, 8'h00, 1, 8'hFF, 0, 1, 0, 0);
        idle(8'h08, 2);
        idle(8'h00, 4);
        tick(1, 8'h00, 1, 8'h00, 1, 0, 0, 0);
        tick(1, 8'h00, 1, 8'h00, 1, 1, 1, 0);
        idle(8'h00, 1);
        // Simultaneous lines 5 and 2
        idle(8'h24, 2);
        idle(8'h00, 4);
        tick(1, 8'h00, 1, 8'h00, 1, 0, 0, 0);
        tick(1, 8'h00, 1, 8'h00, 1, 1, 1, 0);
        idle(8'h00, 2);
        tick(1, 8'h00, 1, 8'h00, 1, 0, 0, 0);
        tick(1, 8'h00, 1, 8'h00, 1, 1, 1, 0);
        // Masked line becomes visible once unmasked
        tick(1, 8'h00, 1, 8'hFB, 0, 1, 0, 0);
        idle(8'h04, 2);
        idle(8'h00, 4);
        tick(1, 8'h00, 1, 8'hFF, 0, 1, 0, 0);
        idle(8'h00, 1);
        tick(1, 8'h00, 1, 8'h00, 1, 0, 0, 0);
        tick(1, 8'h00, 1, 8'h00, 1, 1, 1, 0);
        // Higher-priority arrival after capture
        idle(8'h10, 2);
        idle(8'h00, 3);
        tick(1, 8'h00, 1, 8'h00, 1, 0, 0, 0);
        idle(8'h02, 2);
        idle(8'h00, 3);
        tick(1, 8'h00, 1, 8'h00, 1, 1, 1, 0);
        idle(8'h00, 1);
        tick(1, 8'h00, 1, 8'h00, 1, 0, 0, 0);
        tick(1, 8'h00, 1, 8'h00, 1, 1, 1, 0);
        // Clear-all coinciding with a new edge on line 6
        idle(8'h81, 1);
        idle(8'h00, 4);
        idle(8'h40, 2);
        tick(1, 8'h00, 1, 8'h00, 1, 0, 1, 1);
        idle(8'h00, 2);
        // Line 0 held across reset release, then reset while captured
        tick(0, 8'h01, 1, 8'h00, 1, 1, 0, 0);
        tick(0, 8'h01, 1, 8'h00, 1, 1, 0, 0);
        tick(1, 8'hFF, 1, 8'h01, 0, 1, 0, 0);
        idle(8'h01, 6);
        tick(1, 8'h01, 1, 8'h00, 1, 0, 0, 0);
        tick(0, 8'h01, 1, 8'h00, 1, 1, 0, 0);
        idle(8'h00, 4);
        // Random traffic
        ir = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) ir[b] = ~ir[b];
            tick(($urandom_range(0, 199) != 0), ir,
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom),
                 ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 39) == 0));
        end
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL queue_drain: got %0d entries left expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_controller.md
# interrupt_controller

Collects eight external interrupt request lines, synchronises and edge-detects them, applies a software-writable mask and presents a single `int_pending` to the microcode sequencer, which uses it both as a trap condition (cond_sel 1010) and to divert fetch to the trap microroutine. During the trap microroutine the sequencer drives `ctrl_int_vector_wrt` to capture the winning interrupt's vector onto `int_vector`, then `ctrl_int_ack` to retire it. `ctrl_clear_all_ints` flushes all pending requests.

## Interface
Parameters:
- NUM_IRQ, 8, number of request lines (fixed at 8; priority encoder and vector format depend on it)
- SYNC_STAGES, 2, synchroniser depth before edge detection

Ports:
- clk  in  1  system clock; all state changes on rising edge
- arst_n  in  1  reset, synchronous, active-low
- irq  in  8  asynchronous request lines, active-high, rising-edge triggered; bit 0 highest priority
- irq_en  in  1  global interrupt enable (cpu_status interrupt-enable bit)
- z_bus  in  8  data source for mask writes
- ctrl_mask_flags_wrt  in  1  active-low; loads `mask` from `z_bus`
- ctrl_int_vector_wrt  in  1  active-low; captures the highest-priority unmasked pending line
- ctrl_int_ack  in  1  active-high; retires the captured line
- ctrl_clear_all_ints  in  1  active-high; clears all pending bits and the capture
- int_pending  out  1  to sequencer; request for trap
- int_vector  out  8  captured vector, `{idx[2:0], 5'b00000}`
- int_mask  out  8  mask readback
- int_status  out  8  raw pending bits readback

## Operation
- Per line: a SYNC_STAGES-deep flop chain, then an edge flop. Edge = `sync_last & ~edge_q`. An edge sets `pending[i]`.
- `active = pending & mask`. `idx` = lowest set bit of `active`.
- State machine, 2 states:
  - IDLE: `int_pending = irq_en & |active`. A `ctrl_int_vector_wrt` low with `|active`: `cap_idx <= idx`, `int_vector <= {idx,5'b0}`, go to CAPTURED. A `ctrl_int_vector_wrt` low with `active == 0`: no change, stay IDLE.
  - CAPTURED: `int_pending = 0`. `ctrl_int_ack`: clear `pending[cap_idx]`, go to IDLE. Further vector writes are ignored.
- `ctrl_int_ack` in IDLE has no effect.
- Ack clears only `cap_idx`, not the current `idx`. A higher-priority line arriving after capture stays pending and is taken next.
- `ctrl_clear_all_ints`: `pending <= 0`, go to IDLE. It overrides ack and vector write in the same cycle. `int_vector` holds its last value.
- A new edge on bit i has priority over any clear of bit i in the same cycle (ack or clear_all): the bit ends up set.
- A mask write takes effect from the next cycle and never alters `pending`. Masked lines still latch pending and become visible when unmasked.
- `irq_en` gates only `int_pending`. Capture uses `active` regardless of `irq_en`.

## Timing
- Reset (arst_n low at a clk edge) sets all of the following:
  - sync and edge flops 0, `pending` 0x00, `mask` 0x00
  - `cap_idx` 0, `int_vector` 0x00, state IDLE
  - `int_pending` 0, `int_status` 0x00, `int_mask` 0x00
- Reset asserted mid-operation (CAPTURED or pending nonzero) returns all outputs to the values above on that edge.
- A line held high across reset release registers exactly one edge.
- irq rising before edge N: sync1 at N, sync2 at N+1, `pending` set at N+2. `int_pending` is high after N+2 if the line is unmasked, `irq_en` is high and the state is IDLE. Latency is 3 edges.
- `int_pending` and `int_vector` are driven from registers through combinational logic only, with no extra cycle.
- A vector write at edge M: `int_vector` is valid and `int_pending` low after M.
- An ack at edge K: the pending bit is clear after K. `int_pending` reflects remaining lines after K.
- Back-to-back vector write at M and ack at M+1 is legal.
- Pulses shorter than one clk period may be missed. A line must be low for at least SYNC_STAGES+1 cycles to re-arm.

## Test plan
- Reset, `mask`=0xFF, `irq_en`=1, pulse irq[3] → `int_status`=0x08, and `int_pending` rises exactly 3 edges after the pulse. Vector write → `int_vector`=0x60 and `int_pending`=0. Ack → `int_status`=0x00.
- Simultaneous irq[5] and irq[2] → capture gives `int_vector`=0x40. Ack → `int_pending` re-asserts and the next capture gives 0xA0.
- `mask`=0xFB, pulse irq[2] → `int_status`=0x04 and `int_pending`=0. Write `mask`=0xFF → `int_pending`=1 the next cycle.
- Capture irq[4], then irq[1] rises before the ack → ack clears only bit 4, `int_status`=0x02, next `int_vector`=0x20.
- Pending 0x81, then `ctrl_clear_all_ints` in the same cycle as a new edge on bit 6 → `int_status`=0x40 and state IDLE.
- irq[0] held high through reset release → exactly one pending set. `arst_n` low while CAPTURED → all outputs zero on the next edge.
